serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin one subtraction; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend, unsigned; sampled only on an accepted start.
REQ-006 b  input  WIDTH  subtrahend, unsigned; sampled only on an accepted start.
REQ-007 diff  output  WIDTH  result a-b modulo 2^WIDTH, registered.
REQ-008 borrow  output  1  final borrow-out, registered; 1 iff a < b unsigned.
REQ-009 busy  output  1  high while a subtraction is in progress.
REQ-010 done  output  1  single-cycle pulse marking diff/borrow valid.
REQ-011 bit_out  output  1  current serial difference bit, LSB first, registered.
REQ-012 bit_valid  output  1  high in each cycle bit_out carries a valid difference bit.

Function
REQ-013 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN on start=1; otherwise remain in IDLE.
REQ-015 On an accepted start: latch a and b into shift registers, clear the borrow flip-flop, and clear the bit counter to 0.
REQ-016 In RUN, each edge shall process one bit pair, LSB first: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
REQ-017 In RUN, each edge shall shift d into diff from the MSB end, store bout as the next bin, shift both operand registers right, and increment the counter.
REQ-018 RUN -> DONE on the edge that processes bit WIDTH-1, i.e. exactly WIDTH edges after the start edge.
REQ-019 On that same edge, diff shall hold the full result and borrow the final bout.
REQ-020 DONE -> IDLE after one cycle, or DONE -> RUN if start=1 in that cycle (back-to-back accepted, new operands latched).
REQ-021 busy shall be 1 in RUN and 0 in IDLE and DONE.
REQ-022 done shall be 1 only in DONE.
REQ-023 With start sampled at edge E0, done shall be high in the cycle following edge E0+WIDTH.
REQ-024 bit_valid shall be 1 for exactly WIDTH consecutive cycles after edges E0+1..E0+WIDTH; bit_out shall equal that edge's d.
REQ-025 start while in RUN shall be ignored; operands and progress shall be unaffected.
REQ-026 diff and borrow shall hold their last completed values through IDLE until the next accepted start.
REQ-027 diff and borrow may change bitwise during RUN; consumers use them only when done=1.
REQ-028 Equal operands shall give diff=0 and borrow=0; a=0 with b≠0 shall give the two's-complement wrap and borrow=1.
REQ-029 The bit counter shall be ceil(log2(WIDTH+1)) bits wide and shall never wrap during a RUN.

Reset
REQ-030 When rst=1 at an edge, the next state shall be IDLE regardless of the current state or of start.
REQ-031 Reset shall clear diff, borrow, busy, done, bit_out, bit_valid, the counter, the operand registers and the borrow flip-flop to 0.
REQ-032 Reset mid-RUN shall abandon the operation; no done pulse shall follow.
REQ-033 rst shall take priority over start in the same cycle.

Verification
REQ-034 a=8'h05, b=8'h03, start one cycle -> 8 cycles of bit_valid with bit_out 0,1,0,0,0,0,0,0; then done=1, diff=8'h02, borrow=0.
REQ-035 a=8'h00, b=8'h01 -> done with diff=8'hFF, borrow=1; a=8'hAA, b=8'hAA -> diff=8'h00, borrow=0.
REQ-036 start pulsed with a=8'h10, b=8'h01, then start held high with a=8'hFF, b=8'hFF during RUN -> result diff=8'h0F, borrow=0; busy stays high for exactly 8 cycles.
REQ-037 rst asserted after the 4th RUN edge -> next cycle all outputs 0, state IDLE, no done pulse for 20 following cycles with start=0.
REQ-038 start=1 in the DONE cycle with a=8'h80, b=8'h7F -> RUN re-entered with no IDLE cycle; next done gives diff=8'h01, borrow=0.
REQ-039 Randomised bench: 200 operand pairs each for WIDTH=8 and WIDTH=16, every result checked against (a-b) mod 2^WIDTH and the a<b comparison.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// master drives the request, slave (the subtractor) returns result and serial stream.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             busy;
  logic             done;
  logic             bit_out;
  logic             bit_valid;

  modport master (
    output start, a, b,
    input  diff, borrow, busy, done, bit_out, bit_valid
  );

  modport slave (
    input  start, a, b,
    output diff, borrow, busy, done, bit_out, bit_valid
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a-b computed one bit per clock, LSB first.
// Result and final borrow are registered and held until the next accepted start.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_reg, b_reg, diff_reg;
  logic [WIDTH-1:0] a_shift, b_shift, diff_shift;
  logic [CW-1:0]    cnt_reg;
  logic             bin_reg, borrow_reg, bit_out_reg, bit_valid_reg;
  logic             d_bit, bout_bit, last_bit, accept;
  logic             busy_c, done_c;

  assign d_bit    = a_reg[0] ^ b_reg[0] ^ bin_reg;
  assign bout_bit = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & bin_reg);
  assign last_bit = (cnt_reg == LAST_BIT);
  assign accept   = bus.start && (state_reg != RUN);

  // Operands shift right toward bit 0; the difference fills from the MSB end.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shift[gi]    = a_reg[gi+1];
      assign b_shift[gi]    = b_reg[gi+1];
      assign diff_shift[gi] = diff_reg[gi+1];
    end
  endgenerate
  assign a_shift[WIDTH-1]    = 1'b0;
  assign b_shift[WIDTH-1]    = 1'b0;
  assign diff_shift[WIDTH-1] = d_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = bus.start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg         <= '0;
      b_reg         <= '0;
      diff_reg      <= '0;
      cnt_reg       <= '0;
      bin_reg       <= 1'b0;
      borrow_reg    <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
    end else begin
      bit_valid_reg <= 1'b0;
      if (state_reg == RUN) begin
        a_reg         <= a_shift;
        b_reg         <= b_shift;
        diff_reg      <= diff_shift;
        bin_reg       <= bout_bit;
        cnt_reg       <= cnt_reg + CW'(1);
        bit_out_reg   <= d_bit;
        bit_valid_reg <= 1'b1;
        if (last_bit) borrow_reg <= bout_bit;
      end else if (accept) begin
        a_reg   <= bus.a;
        b_reg   <= bus.b;
        bin_reg <= 1'b0;
        cnt_reg <= '0;
      end
    end
  end

  assign bus.diff      = diff_reg;
  assign bus.borrow    = borrow_reg;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.bit_out   = bit_out_reg;
  assign bus.bit_valid = bit_valid_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor at WIDTH=8 and WIDTH=16,
// with expected results queued at start and compared when done appears.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8))  if8 ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  serial_subtractor #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  typedef struct {
    int          w;
    logic [31:0] diff;
    logic        borrow;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      if8.start = s;
      if8.a     = av[7:0];
      if8.b     = bv[7:0];
    end else begin
      if16.start = s;
      if16.a     = av[15:0];
      if16.b     = bv[15:0];
    end
  endtask

  task automatic snap(input int w, output logic dn, output logic bz, output logic bvld,
                      output logic bo, output logic brw, output logic [31:0] df);
    if (w == 8) begin
      dn = if8.done; bz = if8.busy; bvld = if8.bit_valid;
      bo = if8.bit_out; brw = if8.borrow; df = {24'h0, if8.diff};
    end else begin
      dn = if16.done; bz = if16.busy; bvld = if16.bit_valid;
      bo = if16.bit_out; brw = if16.borrow; df = {16'h0, if16.diff};
    end
  endtask

  // Starts one subtraction at the current negedge and returns in the done cycle.
  // noise=1 holds start high with all-ones operands throughout RUN.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input bit noise);
    logic [31:0] mask, bits, df;
    logic dn, bz, bvld, bo, brw;
    int cyc, nbits, nbusy;
    exp_t e, got;
    mask     = (32'h1 << w) - 32'h1;
    e.w      = w;
    e.diff   = (av - bv) & mask;
    e.borrow = (av & mask) < (bv & mask);
    sb.push_back(e);
    drive(w, 1'b1, av, bv);
    @(negedge clk);
    drive(w, noise, noise ? 32'hFFFF_FFFF : av, noise ? 32'hFFFF_FFFF : bv);
    cyc = 0; nbits = 0; nbusy = 0; bits = '0;
    snap(w, dn, bz, bvld, bo, brw, df);
    check($sformatf("busy_after_start_w%0d", w), {31'b0, bz}, 32'd1);
    while (1'b1) begin
      if (bz) nbusy++;
      if (bvld) begin
        if (nbits < 32) bits[nbits] = bo;
        nbits++;
      end
      if (dn || cyc >= w + 4) break;
      @(negedge clk);
      cyc++;
      if (noise) drive(w, (cyc < w - 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      snap(w, dn, bz, bvld, bo, brw, df);
    end
    check($sformatf("done_seen_w%0d", w), {31'b0, dn}, 32'd1);
    check($sformatf("done_latency_w%0d", w), cyc, w);
    got = sb.pop_front();
    check($sformatf("diff_w%0d", w), df, got.diff);
    check($sformatf("borrow_w%0d", w), {31'b0, brw}, {31'b0, got.borrow});
    check($sformatf("busy_cycles_w%0d", w), nbusy, w);
    check($sformatf("bit_valid_cycles_w%0d", w), nbits, w);
    check($sformatf("serial_bits_w%0d", w), bits, got.diff);
    $display("op w=%0d a=%0h b=%0h -> diff=%0h borrow=%0b (expected %0h/%0b)",
             w, av & mask, bv & mask, df, brw, got.diff, got.borrow);
  endtask

  task automatic check_all_zero(input string tag);
    logic dn, bz, bvld, bo, brw;
    logic [31:0] df;
    snap(8, dn, bz, bvld, bo, brw, df);
    check({tag, "_diff"}, df, 32'd0);
    check({tag, "_borrow"}, {31'b0, brw}, 32'd0);
    check({tag, "_busy"}, {31'b0, bz}, 32'd0);
    check({tag, "_done"}, {31'b0, dn}, 32'd0);
    check({tag, "_bit_out"}, {31'b0, bo}, 32'd0);
    check({tag, "_bit_valid"}, {31'b0, bvld}, 32'd0);
  endtask

  initial begin
    int ndone;
    drive(8, 1'b0, 32'd0, 32'd0);
    drive(16, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 32'h05, 32'h03, 1'b0);
    repeat (3) @(negedge clk);
    check("hold_diff_idle", {24'h0, if8.diff}, 32'h02);
    check("hold_borrow_idle", {31'b0, if8.borrow}, 32'd0);
    check("no_done_idle", {31'b0, if8.done}, 32'd0);

    run_op(8, 32'h00, 32'h01, 1'b0);
    @(negedge clk);
    run_op(8, 32'hAA, 32'hAA, 1'b0);
    @(negedge clk);
    run_op(8, 32'h10, 32'h01, 1'b1);
    @(negedge clk);

    // back-to-back: second start lands in the DONE cycle of the first
    run_op(8, 32'h33, 32'h44, 1'b0);
    run_op(8, 32'h80, 32'h7F, 1'b0);
    @(negedge clk);

    // abandon an operation with reset after the 4th RUN edge
    drive(8, 1'b1, 32'h05, 32'h03);
    @(negedge clk);
    drive(8, 1'b0, 32'h05, 32'h03);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrun_reset");
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (if8.done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);

    repeat (200) begin
      run_op(8, $urandom, $urandom, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    repeat (200) begin
      run_op(16, $urandom, $urandom, 1'b0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
